// File: rtl/key_event_queue.sv
// Sticky per-key press flags plus an in-order FIFO of press codes.
// Optional `KEY_TIMESTAMP_EN adds a free-running counter and a timestamp per queued event.
module key_event_queue #(
  parameter int NUM_KEYS   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16,
  localparam int CODE_W    = $clog2(NUM_KEYS),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic                key_clear,
  input  logic [NUM_KEYS-1:0] clr_mask,
  output logic [NUM_KEYS-1:0] key_reg,
  output logic                any_key,
  output logic                evt_valid,
  output logic [CODE_W-1:0]   evt_code,
  input  logic                evt_ready,
  output logic [CNT_W-1:0]    evt_count,
  output logic                overflow
`ifdef KEY_TIMESTAMP_EN
  , output logic [TS_W-1:0]   evt_ts
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] push_hot;
  logic [NUM_KEYS-1:0] push_sel;
  logic [NUM_KEYS-1:0] key_next;
  logic [CODE_W-1:0]   push_code;
  logic                found;
  logic                pop;
  logic                push;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CODE_W-1:0]   mem_code [FIFO_DEPTH];

  // Lowest-index pending key wins the single push slot each cycle.
  always_comb begin
    push_code = '0;
    push_hot  = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pending[i] && !found) begin
        found       = 1'b1;
        push_code   = CODE_W'(i);
        push_hot[i] = 1'b1;
      end
    end
  end

  assign pop       = (evt_count != '0) && evt_ready;
  assign push      = found && ((evt_count < CNT_W'(FIFO_DEPTH)) || pop);
  assign push_sel  = push ? push_hot : '0;
  assign key_next  = key_clear ? '0 : ((key_reg & ~clr_mask) | key_pulse);
  assign evt_valid = (evt_count != '0);
  assign evt_code  = evt_valid ? mem_code[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg   <= '0;
      any_key   <= 1'b0;
      pending   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      key_reg <= key_next;
      any_key <= |key_next;
      if (key_clear) begin
        pending   <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        evt_count <= '0;
        overflow  <= 1'b0;
      end else begin
        pending <= (pending & ~push_sel) | key_pulse;
        // A re-press on a key still waiting for a FIFO slot is merged, not queued twice.
        if (|(key_pulse & pending & ~push_sel)) overflow <= 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        evt_count <= evt_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !key_clear) mem_code[wr_ptr] <= push_code;
  end

`ifdef KEY_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_pend [NUM_KEYS];
  logic [TS_W-1:0] mem_ts  [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end

  // Coalesced presses keep the timestamp of the first, still-queued press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_pulse[i] && !(pending[i] && !push_sel[i])) ts_pend[i] <= ts_cnt;
      end
      if (push && !key_clear) mem_ts[wr_ptr] <= ts_pend[push_code];
    end
  end

  assign evt_ts = evt_valid ? mem_ts[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue; expected codes (and timestamps) are queued at stimulus time.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_pulse;
  logic        key_clear;
  logic [15:0] clr_mask;
  logic [15:0] key_reg;
  logic        any_key;
  logic        evt_valid;
  logic [3:0]  evt_code;
  logic        evt_ready;
  logic [3:0]  evt_count;
  logic        overflow;
`ifdef KEY_TIMESTAMP_EN
  logic [15:0] evt_ts;
  logic [15:0] tb_ts;
`endif

  int compared   = 0;
  int mismatched = 0;
  int sbq[$];
  int tsq[$];

  key_event_queue dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .key_clear(key_clear),
    .clr_mask(clr_mask), .key_reg(key_reg), .any_key(any_key),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_count(evt_count), .overflow(overflow)
`ifdef KEY_TIMESTAMP_EN
    , .evt_ts(evt_ts)
`endif
  );

  always #5 clk = ~clk;

`ifdef KEY_TIMESTAMP_EN
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 1'b1;
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    int exp_code;
    chk({tag, "_valid"}, evt_valid, 1);
    chk({tag, "_sb_nonempty"}, sbq.size() > 0, 1);
    exp_code = (sbq.size() > 0) ? sbq.pop_front() : 0;
    chk({tag, "_code"}, evt_code, exp_code);
`ifdef KEY_TIMESTAMP_EN
    if (tsq.size() > 0) chk({tag, "_ts"}, evt_ts, tsq.pop_front());
`endif
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_pulse = '0; key_clear = 1'b0; clr_mask = '0; evt_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_key_reg", key_reg, 0);
    chk("rst_any_key", any_key, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_overflow", overflow, 0);

    // single press latency
    key_pulse = 16'h0008; sbq.push_back(3);
    tick();
    key_pulse = '0;
    chk("t1_key_reg", key_reg, 16'h0008);
    chk("t1_any_key", any_key, 1);
    chk("t1_valid_e0", evt_valid, 0);
    tick();
    chk("t1_count", evt_count, 1);
    chk("t1_overflow", overflow, 0);
    pop_check("t1_pop");
    chk("t1_count_after", evt_count, 0);

    // simultaneous presses serialised lowest-first
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    key_pulse = 16'h8101; sbq.push_back(0); sbq.push_back(8); sbq.push_back(15);
    tick();
    key_pulse = '0;
    chk("t2_key_reg", key_reg, 16'h8101);
    tick(); tick(); tick();
    chk("t2_count_peak", evt_count, 3);
    pop_check("t2_pop0");
    pop_check("t2_pop1");
    pop_check("t2_pop2");
    chk("t2_count_end", evt_count, 0);

    // full FIFO, pending backlog, coalesce
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    key_pulse = 16'h00FF;
    for (int i = 0; i < 8; i++) sbq.push_back(i);
    tick();
    key_pulse = '0;
    repeat (8) tick();
    chk("t3_full_count", evt_count, 8);
    key_pulse = 16'h0300; sbq.push_back(8); sbq.push_back(9);
    tick();
    key_pulse = '0;
    tick();
    chk("t3_held_count", evt_count, 8);
    chk("t3_no_ovf", overflow, 0);
    chk("t3_key_reg", key_reg, 16'h03FF);
    key_pulse = 16'h0200;
    tick();
    key_pulse = '0;
    chk("t3_ovf", overflow, 1);
    pop_check("t3_pop_first");
    chk("t3_count_pushpop", evt_count, 8);
    for (int i = 0; i < 12 && sbq.size() > 0; i++) pop_check("t3_drain");
    chk("t3_drained", sbq.size(), 0);
    tick();
    chk("t3_empty_valid", evt_valid, 0);
    chk("t3_empty_count", evt_count, 0);

    // set beats per-bit clear; clear alone leaves FIFO alone
    clr_mask = 16'h0001; key_pulse = 16'h0001; sbq.push_back(0);
    tick();
    key_pulse = '0;
    chk("t4_set_wins", key_reg, 16'h03FF);
    tick();
    clr_mask = '0;
    chk("t4_bit_clear", key_reg, 16'h03FE);
    chk("t4_fifo_count", evt_count, 1);
    pop_check("t4_pop");

    // global clear beats push, pop and new pulses
    key_pulse = 16'h0070;
    tick();
    key_pulse = '0;
    repeat (3) tick();
    chk("t5_count3", evt_count, 3);
    chk("t5_ovf_still", overflow, 1);
    key_clear = 1'b1; key_pulse = 16'h0004; evt_ready = 1'b1;
    tick();
    key_clear = 1'b0; key_pulse = '0; evt_ready = 1'b0;
    sbq.delete();
    chk("t5_key_reg", key_reg, 0);
    chk("t5_any_key", any_key, 0);
    chk("t5_valid", evt_valid, 0);
    chk("t5_count", evt_count, 0);
    chk("t5_ovf", overflow, 0);
    repeat (3) tick();
    chk("t5_no_key2", evt_valid, 0);

    // reset mid-operation
    key_pulse = 16'h0002;
    tick();
    key_pulse = '0;
    rst = 1'b1;
    #1;
    chk("t6_rst_key_reg", key_reg, 0);
    chk("t6_rst_valid", evt_valid, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_no_partial", evt_valid, 0);
    chk("t6_count", evt_count, 0);

`ifdef KEY_TIMESTAMP_EN
    for (int i = 0; i < 500 && tb_ts != 16'd100; i++) tick();
    chk("ts_wait100", tb_ts, 100);
    key_pulse = 16'h0020; sbq.push_back(5); tsq.push_back(100);
    tick();
    key_pulse = '0;
    for (int i = 0; i < 50 && tb_ts != 16'd103; i++) tick();
    chk("ts_wait103", tb_ts, 103);
    key_pulse = 16'h0040; sbq.push_back(6); tsq.push_back(103);
    tick();
    key_pulse = '0;
    tick(); tick();
    pop_check("ts_pop5");
    pop_check("ts_pop6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
